// File: rtl/aes_decrypt_ctrl.sv
// -----------------------------------------------------------------------------
// aes_decrypt_ctrl
//
// Sequencer for the iterative AES-128 decryption datapath. A level start
// (Start register bit 0) launches one decryption: load the ciphertext, kick
// key expansion, wait for the schedule, apply the last round key, then walk
// the inverse rounds (InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns),
// with InvMixColumns omitted on the final round. Completion is held on
// AES_DONE until software clears Start.
//
// Build option:
//   AES_CTRL_SERIAL_MIX_EN  when defined, InvMixColumns is issued one column
//                           per cycle (COL_SEL 0..3, four writes per round);
//                           when undefined it is a single cycle, COL_SEL = 0.
//
// Parameters:
//   NUM_ROUNDS     cipher rounds, 1..15
//   KEYEXP_CYCLES  cycles to wait after KEYEXP_GO for the key schedule, >= 1
//
// Ports:
//   CLK        in   system clock, rising edge
//   RESET      in   synchronous, active-high reset
//   AES_START  in   level start request
//   AES_DONE   out  decryption complete, held until AES_START falls
//   BUSY       out  high in every state other than IDLE and DONE
//   KEYEXP_GO  out  one-cycle key-expansion start pulse
//   OP_SEL     out  0 NOP, 1 LOAD, 2 INV_SHIFT, 3 INV_SUB, 4 ADD_KEY, 5 INV_MIX
//   STATE_WE   out  state-register write enable (OP_SEL != NOP)
//   RK_IDX     out  round-key index during ADD_KEY, else 0
//   COL_SEL    out  InvMixColumns column in serial mode, else 0
//
// All outputs are decoded from registered state only; none follow AES_START
// combinationally.
// -----------------------------------------------------------------------------
module aes_decrypt_ctrl #(
  parameter int NUM_ROUNDS    = 10,
  parameter int KEYEXP_CYCLES = 10
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       AES_START,
  output logic       AES_DONE,
  output logic       BUSY,
  output logic       KEYEXP_GO,
  output logic [2:0] OP_SEL,
  output logic       STATE_WE,
  output logic [3:0] RK_IDX,
  output logic [1:0] COL_SEL
);

  localparam int KE_W = $clog2(KEYEXP_CYCLES + 1);
  localparam logic [KE_W-1:0] KE_LAST = KE_W'(KEYEXP_CYCLES);
  localparam logic [3:0]      NR      = 4'(NUM_ROUNDS);

  localparam logic [2:0] OP_NOP       = 3'd0;
  localparam logic [2:0] OP_LOAD      = 3'd1;
  localparam logic [2:0] OP_INV_SHIFT = 3'd2;
  localparam logic [2:0] OP_INV_SUB   = 3'd3;
  localparam logic [2:0] OP_ADD_KEY   = 3'd4;
  localparam logic [2:0] OP_INV_MIX   = 3'd5;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_KEYEXP,
    S_ARK0,
    S_SHIFT,
    S_SUB,
    S_ARK,
    S_MIX,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      rnd_q, rnd_d;     // current inverse round, 1..NUM_ROUNDS
  logic [KE_W-1:0] ke_q, ke_d;       // cycles spent in KEYEXP, 1..KEYEXP_CYCLES
`ifdef AES_CTRL_SERIAL_MIX_EN
  logic [1:0]      col_q, col_d;     // InvMixColumns column being written
`endif

  logic in_run;

  // ---------------------------------------------------------------------------
  // State and counter registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      rnd_q   <= '0;
      ke_q    <= '0;
`ifdef AES_CTRL_SERIAL_MIX_EN
      col_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      ke_q    <= ke_d;
`ifdef AES_CTRL_SERIAL_MIX_EN
      col_q   <= col_d;
`endif
    end
  end

  // States in which dropping AES_START aborts the run.
  assign in_run = (state_q != S_IDLE) && (state_q != S_DONE);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    ke_d    = ke_q;
`ifdef AES_CTRL_SERIAL_MIX_EN
    col_d   = col_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (AES_START) begin
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        // The KEYEXP count starts at 1 so KE_LAST marks the final wait cycle.
        state_d = S_KEYEXP;
        ke_d    = KE_W'(1);
      end

      S_KEYEXP: begin
        if (ke_q == KE_LAST) begin
          state_d = S_ARK0;
        end else begin
          ke_d = ke_q + 1'b1;
        end
      end

      S_ARK0: begin
        state_d = S_SHIFT;
        rnd_d   = 4'd1;
      end

      S_SHIFT: begin
        state_d = S_SUB;
      end

      S_SUB: begin
        state_d = S_ARK;
      end

      S_ARK: begin
        // The final round has no InvMixColumns.
        if (rnd_q == NR) begin
          state_d = S_DONE;
        end else begin
          state_d = S_MIX;
`ifdef AES_CTRL_SERIAL_MIX_EN
          col_d   = 2'd0;
`endif
        end
      end

      S_MIX: begin
`ifdef AES_CTRL_SERIAL_MIX_EN
        if (col_q == 2'd3) begin
          state_d = S_SHIFT;
          rnd_d   = rnd_q + 4'd1;
          col_d   = 2'd0;
        end else begin
          col_d = col_q + 2'd1;
        end
`else
        state_d = S_SHIFT;
        rnd_d   = rnd_q + 4'd1;
`endif
      end

      S_DONE: begin
        if (!AES_START) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Software clearing Start mid-run abandons the decryption; this also
    // covers the gaps between serial InvMixColumns columns.
    if (in_run && !AES_START) begin
      state_d = S_IDLE;
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode (state only)
  // ---------------------------------------------------------------------------
  always_comb begin
    AES_DONE  = 1'b0;
    KEYEXP_GO = 1'b0;
    OP_SEL    = OP_NOP;
    RK_IDX    = 4'd0;
    COL_SEL   = 2'd0;

    unique case (state_q)
      S_LOAD: begin
        OP_SEL    = OP_LOAD;
        KEYEXP_GO = 1'b1;
      end
      S_ARK0: begin
        OP_SEL = OP_ADD_KEY;
        RK_IDX = NR;
      end
      S_SHIFT: begin
        OP_SEL = OP_INV_SHIFT;
      end
      S_SUB: begin
        OP_SEL = OP_INV_SUB;
      end
      S_ARK: begin
        // Round keys are consumed in reverse order of the schedule.
        OP_SEL = OP_ADD_KEY;
        RK_IDX = NR - rnd_q;
      end
      S_MIX: begin
        OP_SEL = OP_INV_MIX;
`ifdef AES_CTRL_SERIAL_MIX_EN
        COL_SEL = col_q;
`endif
      end
      S_DONE: begin
        AES_DONE = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign BUSY     = in_run;
  assign STATE_WE = (OP_SEL != OP_NOP);

endmodule
